pc_unit: RTL and testbench

- Parametrised program-counter unit.
- Holds the fetch address in a clocked register and selects the next PC from these sources: sequential, branch-relative, absolute jump, call, return, or external redirect.
- Includes a circular return-address stack (RAS) for call/return.
- Sits in front of the instruction memory; pc_o drives the instruction-memory read address.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;
  localparam int PC_W_DEF      = 32;
  localparam int INC_DEF       = 4;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_REDIR,
    SEL_HOLD
  } pc_sel_e;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, push+pop swap, saturating count, underflow pulse.
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] link_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            uflow_o
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [RAS_DEPTH-1:0][PC_W-1:0] mem_q;
  logic [PW-1:0]                  ptr_q, ptr_d, wr_idx;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           uflow_q, uflow_d, wr_en;

  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(RAS_DEPTH));
  assign uflow_o = uflow_q;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    uflow_d = 1'b0;
    if (push_i && pop_i) begin
      // Swap rewrites the top slot in place; an empty stack gains its first entry there.
      wr_en = 1'b1;
      if (empty_o) cnt_d = CW'(1);
    end else if (push_i) begin
      ptr_d  = ptr_q + PW'(1);
      wr_idx = ptr_d;
      wr_en  = 1'b1;
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i) begin
      if (empty_o) uflow_d = 1'b1;
      else begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
      if (wr_en) mem_q[wr_idx] <= link_i;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Program-counter register with prioritised next-PC select and return-address stack.
// Optional low-bit alignment correction enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              INC       = INC_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] branch_off_i,
  input  logic            jump_i,
  input  logic            call_i,
  input  logic [PC_W-1:0] jump_tgt_i,
  input  logic            ret_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_uflow_o,
  output logic            misalign_o
);
  logic [PC_W-1:0] pc_q, pc_seq, ras_top, raw_next;
  logic            ras_push, ras_pop;
  pc_sel_e         sel;

  assign pc_o   = pc_q;
  assign pc_seq = pc_q + PC_W'(INC);

  // Stack only moves when the request actually advances the PC.
  assign ras_push = call_i & ~stall_i & ~redirect_i;
  assign ras_pop  = ret_i  & ~stall_i & ~redirect_i;

  always_comb begin
    sel = SEL_SEQ;
    if (redirect_i)           sel = SEL_REDIR;
    else if (stall_i)         sel = SEL_HOLD;
    else if (ret_i)           sel = SEL_RET;
    else if (call_i | jump_i) sel = SEL_JMP;
    else if (branch_i)        sel = SEL_BR;
  end

  always_comb begin
    raw_next = pc_seq;
    case (sel)
      SEL_REDIR: raw_next = redirect_pc_i;
      SEL_HOLD:  raw_next = pc_q;
      SEL_RET:   raw_next = ras_empty_o ? pc_seq : ras_top;
      SEL_JMP:   raw_next = jump_tgt_i;
      SEL_BR:    raw_next = pc_q + branch_off_i;
      default:   raw_next = pc_seq;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(INC - 1);
  logic misalign_q;

  assign pc_next_o  = raw_next & ~LOW_MASK;
  assign misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= |(raw_next & LOW_MASK);
  end
`else
  assign pc_next_o  = raw_next;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_next_o;
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .link_i  (pc_seq),
    .top_o   (ras_top),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o),
    .uflow_o (ras_uflow_o)
  );
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 0, branch_i = 0, jump_i = 0, call_i = 0, ret_i = 0, redirect_i = 0;
  logic [31:0] branch_off_i = '0, jump_tgt_i = '0, redirect_pc_i = '0;
  logic [31:0] pc_o, pc_next_o;
  logic        ras_empty_o, ras_full_o, ras_uflow_o, misalign_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: PC value and the live return addresses, oldest first.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_uflow, m_mis;
  logic [31:0] exp_next, obs_next;

  pc_unit #(.PC_W(32), .INC(4), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .branch_i(branch_i),
    .branch_off_i(branch_off_i), .jump_i(jump_i), .call_i(call_i),
    .jump_tgt_i(jump_tgt_i), .ret_i(ret_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .pc_o(pc_o), .pc_next_o(pc_next_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
    .ras_uflow_o(ras_uflow_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_uflow = 1'b0;
    m_mis = 1'b0;
  endtask

  // Drive one cycle of requests, predict the outcome, and advance past the edge.
  task automatic step(input logic st, input logic rd, input logic rt, input logic cl,
                      input logic jp, input logic br, input logic [31:0] off,
                      input logic [31:0] tgt, input logic [31:0] rpc);
    logic [31:0] nxt;
    logic        uf;
    stall_i = st; redirect_i = rd; ret_i = rt; call_i = cl; jump_i = jp; branch_i = br;
    branch_off_i = off; jump_tgt_i = tgt; redirect_pc_i = rpc;
    uf = 1'b0;
    if (rd) nxt = rpc;
    else if (st) nxt = m_pc;
    else if (rt) begin
      nxt = (m_ras.size() > 0) ? m_ras[$] : m_pc + 32'd4;
      if (cl) begin
        if (m_ras.size() == 0) m_ras.push_back(m_pc + 32'd4);
        else m_ras[m_ras.size()-1] = m_pc + 32'd4;
      end else if (m_ras.size() > 0) void'(m_ras.pop_back());
      else uf = 1'b1;
    end else if (cl || jp) begin
      nxt = tgt;
      if (cl) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end else if (br) nxt = m_pc + off;
    else nxt = m_pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
    m_mis = (nxt[1:0] != 2'b00);
    nxt[1:0] = 2'b00;
`else
    m_mis = 1'b0;
`endif
    exp_next = nxt;
    #1 obs_next = pc_next_o;
    @(posedge clk); #1;
    m_pc = nxt;
    m_uflow = uf;
  endtask

  task automatic idle(); step(0,0,0,0,0,0,'0,'0,'0); endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (pc_o !== 32'h0 || ras_empty_o !== 1'b1 || ras_full_o !== 1'b0 ||
        ras_uflow_o !== 1'b0 || misalign_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h empty=%b full=%b uflow=%b mis=%b", pc_o, ras_empty_o,
               ras_full_o, ras_uflow_o, misalign_o);
    end
    for (int i = 1; i <= 3; i++) begin
      idle();
      tests_run++;
      if (pc_o !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL reset_seq[%0d]: got %h want %h", i, pc_o, 32'(4 * i));
      end
    end
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (pc_o !== 32'h0 || ras_empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h empty=%b want pc=0 empty=1", pc_o, ras_empty_o);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_branch_stall();
    repeat (4) idle();
    tests_run++;
    if (pc_o !== 32'h10) begin
      tests_failed++;
      $display("FAIL branch_setup: got %h want 00000010", pc_o);
    end
    step(0,0,0,0,0,1,32'hFFFF_FFF8,'0,'0);
    tests_run++;
    if (pc_o !== 32'h08 || pc_o !== m_pc) begin
      tests_failed++;
      $display("FAIL branch_back: got %h want 00000008", pc_o);
    end
    step(1,0,0,0,1,0,'0,32'h4000,'0);
    tests_run++;
    if (pc_o !== 32'h08 || obs_next !== 32'h08) begin
      tests_failed++;
      $display("FAIL stall_jump: pc=%h next=%h want 00000008", pc_o, obs_next);
    end
  endtask

  task automatic test_call_ret();
    step(0,0,0,0,1,0,'0,32'h20,'0);
    step(0,0,0,1,0,0,'0,32'h100,'0);
    tests_run++;
    if (pc_o !== 32'h100 || ras_empty_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL call1: pc=%h empty=%b want 00000100 0", pc_o, ras_empty_o);
    end
    idle();
    step(0,0,0,1,0,0,'0,32'h200,'0);
    tests_run++;
    if (pc_o !== 32'h200) begin
      tests_failed++;
      $display("FAIL call2: got %h want 00000200", pc_o);
    end
    step(0,0,1,0,0,0,'0,'0,'0);
    tests_run++;
    if (pc_o !== 32'h108) begin
      tests_failed++;
      $display("FAIL ret1: got %h want 00000108", pc_o);
    end
    step(0,0,1,0,0,0,'0,'0,'0);
    tests_run++;
    if (pc_o !== 32'h24 || ras_empty_o !== 1'b1 || ras_uflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ret2: pc=%h empty=%b uflow=%b want 00000024 1 0", pc_o, ras_empty_o, ras_uflow_o);
    end
  endtask

  task automatic test_ras_full();
    logic [31:0] want;
    for (int k = 1; k <= 5; k++) begin
      step(0,0,0,1,0,0,'0,32'(k * 32'h1000),'0);
      if (k == 4) begin
        tests_run++;
        if (ras_full_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL ras_full_after4: got %b want 1", ras_full_o);
        end
      end
    end
    for (int k = 4; k >= 1; k--) begin
      step(0,0,1,0,0,0,'0,'0,'0);
      want = 32'(k * 32'h1000 + 4);
      tests_run++;
      if (pc_o !== want) begin
        tests_failed++;
        $display("FAIL ras_pop[%0d]: got %h want %h", k, pc_o, want);
      end
    end
    step(0,0,1,0,0,0,'0,'0,'0);
    tests_run++;
    if (pc_o !== 32'h1008 || ras_uflow_o !== 1'b1 || ras_empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ras_uflow: pc=%h uflow=%b empty=%b want 00001008 1 1", pc_o, ras_uflow_o, ras_empty_o);
    end
    idle();
    tests_run++;
    if (ras_uflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL uflow_pulse_end: got %b want 0", ras_uflow_o);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] link;
    link = m_pc + 32'd4;
    step(0,0,0,1,0,0,'0,32'h600,'0);
    step(1,1,1,0,0,0,'0,'0,32'h8000);
    tests_run++;
    if (pc_o !== 32'h8000 || ras_empty_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect: pc=%h empty=%b want 00008000 0", pc_o, ras_empty_o);
    end
    step(0,0,1,0,0,0,'0,'0,'0);
    tests_run++;
    if (pc_o !== link || ras_empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL redirect_ras_kept: pc=%h want %h", pc_o, link);
    end
  endtask

  task automatic test_align();
    step(0,0,0,0,1,0,'0,32'h103,'0);
`ifdef PC_ALIGN_CHECK_EN
    tests_run++;
    if (pc_o !== 32'h100 || misalign_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL align_jump: pc=%h mis=%b want 00000100 1", pc_o, misalign_o);
    end
`else
    tests_run++;
    if (pc_o !== 32'h103 || misalign_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL align_jump: pc=%h mis=%b want 00000103 0", pc_o, misalign_o);
    end
`endif
    step(0,0,0,0,1,0,'0,32'h300,'0);
    tests_run++;
    if (misalign_o !== 1'b0 || pc_o !== 32'h300) begin
      tests_failed++;
      $display("FAIL align_clear: pc=%h mis=%b want 00000300 0", pc_o, misalign_o);
    end
  endtask

  task automatic test_random();
    logic st, rd, rt, cl, jp, br;
    logic [31:0] off, tgt, rpc;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rt  = ($urandom_range(0, 3) == 0);
      cl  = ($urandom_range(0, 3) == 0);
      jp  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 2) == 0);
      off = 32'($signed(32'($urandom_range(0, 128)) * 4) - 256);
      tgt = $urandom;
      rpc = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        tgt[1:0] = 2'b00;
        rpc[1:0] = 2'b00;
      end
      step(st, rd, rt, cl, jp, br, off, tgt, rpc);
      tests_run++;
      if (obs_next !== exp_next || pc_o !== m_pc) begin
        tests_failed++;
        $display("FAIL rand_pc[%0d]: next=%h pc=%h want next=%h pc=%h", i, obs_next, pc_o, exp_next, m_pc);
      end
      tests_run++;
      if (ras_empty_o !== (m_ras.size() == 0) || ras_full_o !== (m_ras.size() == DEPTH) ||
          ras_uflow_o !== m_uflow || misalign_o !== m_mis) begin
        tests_failed++;
        $display("FAIL rand_flags[%0d]: e/f/u/m=%b%b%b%b want %b%b%b%b", i, ras_empty_o, ras_full_o,
                 ras_uflow_o, misalign_o, (m_ras.size() == 0), (m_ras.size() == DEPTH), m_uflow, m_mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_call_ret();
    test_ras_full();
    test_redirect();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
